// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the decode-to-execute stage of the 5-stage MIPS core:
//   - default datapath and register-address widths
//   - 4-bit ALU opcodes (OP_ADD .. OP_BEQ)
//   - forwarding-select encodings used between fwd_unit and the operand muxes
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

  localparam int DSIZE_DEF = 32;
  localparam int ASIZE_DEF = 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_BEQ = 4'd8;

  // Operand source selected by the forwarding unit.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,  // value captured in the stage register
    FWD_EXM = 2'd1,  // EX/MEM result (youngest)
    FWD_WB  = 2'd2   // MEM/WB result
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Chooses where one ALU source operand comes from, given the register number
// held in the ID/EX stage and the two writeback buses still in flight.
// Ports:
//   reg_num    in   source register number held in ID/EX
//   exm_wr_en  in   EX/MEM writeback enable
//   exm_rd     in   EX/MEM destination register
//   wb_wr_en   in   MEM/WB writeback enable
//   wb_rd      in   MEM/WB destination register
//   sel        out  2-bit select (FWD_REG / FWD_EXM / FWD_WB)
// ---------------------------------------------------------------------------
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic [ASIZE-1:0] reg_num,
  input  logic             exm_wr_en,
  input  logic [ASIZE-1:0] exm_rd,
  input  logic             wb_wr_en,
  input  logic [ASIZE-1:0] wb_rd,
  output logic [1:0]       sel
);

  // r0 is hard-wired zero, so a write to it must never be forwarded.
  // EX/MEM is checked first because it carries the younger value.
  always_comb begin
    sel = FWD_REG;
    if (reg_num != '0) begin
      if (exm_wr_en && (exm_rd == reg_num)) begin
        sel = FWD_EXM;
      end else if (wb_wr_en && (wb_rd == reg_num)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS core. Captures the decoded
// instruction, forwards EX/MEM and MEM/WB results into the ALU operands,
// detects load-use hazards (stall + bubble) and kills the decode slot on a
// taken branch (flush).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_*                        decoded instruction from the ID stage
//   flush                       taken branch: load a bubble
//   exm_wr_en/exm_rd/exm_data   EX/MEM writeback bus
//   wb_wr_en/wb_rd/wb_data      MEM/WB writeback bus
//   stall                       combinational: hold PC and IF/ID
//   ex_valid/ex_wr_en/ex_mem_rd/ex_mem_wr/ex_op/ex_rd/ex_imm  registered
//   ex_a/ex_b/ex_st_data        forwarded operands (combinational)
// ---------------------------------------------------------------------------
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_op,
  input  logic [ASIZE-1:0] id_rs,
  input  logic [ASIZE-1:0] id_rt,
  input  logic [ASIZE-1:0] id_rd,
  input  logic [DSIZE-1:0] id_rs_data,
  input  logic [DSIZE-1:0] id_rt_data,
  input  logic [DSIZE-1:0] id_imm,
  input  logic             id_use_imm,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic             id_mem_rd,
  input  logic             id_mem_wr,
  input  logic             flush,
  input  logic             exm_wr_en,
  input  logic [ASIZE-1:0] exm_rd,
  input  logic [DSIZE-1:0] exm_data,
  input  logic             wb_wr_en,
  input  logic [ASIZE-1:0] wb_rd,
  input  logic [DSIZE-1:0] wb_data,
  output logic             stall,
  output logic             ex_valid,
  output logic             ex_wr_en,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic [3:0]       ex_op,
  output logic [ASIZE-1:0] ex_rd,
  output logic [DSIZE-1:0] ex_imm,
  output logic [DSIZE-1:0] ex_a,
  output logic [DSIZE-1:0] ex_b,
  output logic [DSIZE-1:0] ex_st_data
);

  logic             valid_q,   valid_d;
  logic             wr_en_q,   wr_en_d;
  logic             mem_rd_q,  mem_rd_d;
  logic             mem_wr_q,  mem_wr_d;
  logic             use_imm_q, use_imm_d;
  logic [3:0]       op_q,      op_d;
  logic [ASIZE-1:0] rd_q,      rd_d;
  logic [ASIZE-1:0] rs_q,      rs_d;
  logic [ASIZE-1:0] rt_q,      rt_d;
  logic [DSIZE-1:0] rs_data_q, rs_data_d;
  logic [DSIZE-1:0] rt_data_q, rt_data_d;
  logic [DSIZE-1:0] imm_q,     imm_d;

  logic             load_use;
  logic             rs_wb_hit;
  logic             rt_wb_hit;
  logic [1:0]       rs_sel;
  logic [1:0]       rt_sel;
  logic [DSIZE-1:0] rs_fwd;
  logic [DSIZE-1:0] rt_fwd;

  // -------------------------------------------------------------------------
  // Hazard detection (ID stage, combinational)
  // A load in EX cannot forward its data yet; hold decode for one cycle.
  // The inserted bubble clears mem_rd_q, so the stall self-terminates.
  // -------------------------------------------------------------------------
  always_comb begin
    load_use = id_valid && valid_q && mem_rd_q && (rd_q != '0) &&
               ((rd_q == id_rs) || (id_use_rt && (rd_q == id_rt)));
    // A taken branch kills the decode slot, so there is nothing to hold.
    stall    = load_use && !flush;
  end

  // The register file is written at the end of the cycle, so a value being
  // written back right now is not yet visible on id_*_data.
  always_comb begin
    rs_wb_hit = wb_wr_en && (wb_rd != '0) && (wb_rd == id_rs);
    rt_wb_hit = wb_wr_en && (wb_rd != '0) && (wb_rd == id_rt);
  end

  always_comb begin
    valid_d   = 1'b0;
    wr_en_d   = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    use_imm_d = 1'b0;
    op_d      = OP_ADD;
    rd_d      = '0;
    rs_d      = '0;
    rt_d      = '0;
    rs_data_d = '0;
    rt_data_d = '0;
    imm_d     = '0;
    if (!flush && !stall) begin
      valid_d   = id_valid;
      wr_en_d   = id_wr_en;
      mem_rd_d  = id_mem_rd;
      mem_wr_d  = id_mem_wr;
      use_imm_d = id_use_imm;
      op_d      = id_op;
      rd_d      = id_rd;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rs_data_d = rs_wb_hit ? wb_data : id_rs_data;
      rt_data_d = rt_wb_hit ? wb_data : id_rt_data;
      imm_d     = id_imm;
    end
  end

  // -------------------------------------------------------------------------
  // ID/EX stage registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      use_imm_q <= 1'b0;
      op_q      <= OP_ADD;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      wr_en_q   <= wr_en_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      use_imm_q <= use_imm_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  // -------------------------------------------------------------------------
  // EX stage operand forwarding (combinational, no register after the mux)
  // -------------------------------------------------------------------------
  fwd_unit #(.ASIZE(ASIZE)) u_fwd_rs (
    .reg_num   (rs_q),
    .exm_wr_en (exm_wr_en),
    .exm_rd    (exm_rd),
    .wb_wr_en  (wb_wr_en),
    .wb_rd     (wb_rd),
    .sel       (rs_sel)
  );

  fwd_unit #(.ASIZE(ASIZE)) u_fwd_rt (
    .reg_num   (rt_q),
    .exm_wr_en (exm_wr_en),
    .exm_rd    (exm_rd),
    .wb_wr_en  (wb_wr_en),
    .wb_rd     (wb_rd),
    .sel       (rt_sel)
  );

  always_comb begin
    case (rs_sel)
      FWD_EXM: rs_fwd = exm_data;
      FWD_WB:  rs_fwd = wb_data;
      default: rs_fwd = rs_data_q;
    endcase
    case (rt_sel)
      FWD_EXM: rt_fwd = exm_data;
      FWD_WB:  rt_fwd = wb_data;
      default: rt_fwd = rt_data_q;
    endcase
  end

  always_comb begin
    ex_valid   = valid_q;
    ex_wr_en   = wr_en_q;
    ex_mem_rd  = mem_rd_q;
    ex_mem_wr  = mem_wr_q;
    ex_op      = op_q;
    ex_rd      = rd_q;
    ex_imm     = imm_q;
    ex_a       = rs_fwd;
    ex_b       = use_imm_q ? imm_q : rt_fwd;
    // Stores always need the real rt value, even when operand b is the offset.
    ex_st_data = rt_fwd;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed-vector bench for id_ex_stage. Each cycle a driver applies one
// vector just after the rising edge and queues the hand-computed outputs for
// that cycle; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 12;

  typedef struct {
    logic          rst_n;
    logic          id_valid;
    logic [3:0]    id_op;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          id_use_imm, id_use_rt, id_wr_en, id_mem_rd, id_mem_wr;
    logic          flush;
    logic          exm_wr_en;
    logic [AW-1:0] exm_rd;
    logic [DW-1:0] exm_data;
    logic          wb_wr_en;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
  } vec_t;

  typedef struct {
    string         name;
    logic [DW-1:0] val [NF];
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [3:0]    id_op = '0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic [DW-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic          id_use_imm = 1'b0, id_use_rt = 1'b0, id_wr_en = 1'b0;
  logic          id_mem_rd = 1'b0, id_mem_wr = 1'b0, flush = 1'b0;
  logic          exm_wr_en = 1'b0;
  logic [AW-1:0] exm_rd = '0;
  logic [DW-1:0] exm_data = '0;
  logic          wb_wr_en = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0;

  logic          stall, ex_valid, ex_wr_en, ex_mem_rd, ex_mem_wr;
  logic [3:0]    ex_op;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_imm, ex_a, ex_b, ex_st_data;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  string fname [NF] = '{"stall", "ex_valid", "ex_wr_en", "ex_mem_rd", "ex_mem_wr",
                        "ex_op", "ex_rd", "ex_imm", "ex_a", "ex_b", "ex_st_data",
                        "pad"};

  id_ex_stage #(.DSIZE(DW), .ASIZE(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .flush(flush),
    .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall),
    .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_imm(ex_imm),
    .ex_a(ex_a), .ex_b(ex_b), .ex_st_data(ex_st_data)
  );

  always #5 clk = ~clk;

  function automatic vec_t nop();
    vec_t v;
    v.rst_n = 1'b1;  v.id_valid = 1'b0; v.id_op = 4'd0;
    v.id_rs = '0;    v.id_rt = '0;      v.id_rd = '0;
    v.id_rs_data = '0; v.id_rt_data = '0; v.id_imm = '0;
    v.id_use_imm = 1'b0; v.id_use_rt = 1'b0; v.id_wr_en = 1'b0;
    v.id_mem_rd = 1'b0;  v.id_mem_wr = 1'b0; v.flush = 1'b0;
    v.exm_wr_en = 1'b0;  v.exm_rd = '0; v.exm_data = '0;
    v.wb_wr_en = 1'b0;   v.wb_rd = '0;  v.wb_data = '0;
    return v;
  endfunction

  // Instruction in decode: op, rd, rs, rt, rs_data, rt_data, imm, use_imm, use_rt, wr, mrd, mwr
  function automatic vec_t ins(input logic [3:0] op, input int rd, input int rs, input int rt,
                               input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                               input logic [DW-1:0] imm, input logic ui, input logic ur,
                               input logic wr, input logic mrd, input logic mwr);
    vec_t v = nop();
    v.id_valid = 1'b1; v.id_op = op;
    v.id_rd = AW'(rd); v.id_rs = AW'(rs); v.id_rt = AW'(rt);
    v.id_rs_data = rsd; v.id_rt_data = rtd; v.id_imm = imm;
    v.id_use_imm = ui; v.id_use_rt = ur;
    v.id_wr_en = wr; v.id_mem_rd = mrd; v.id_mem_wr = mwr;
    return v;
  endfunction

  function automatic exp_t ex(input string nm, input logic st, input logic vl, input logic wr,
                              input logic mrd, input logic mwr, input logic [3:0] op,
                              input int rd, input logic [DW-1:0] imm, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [DW-1:0] sd);
    exp_t e;
    e.name = nm;
    e.val[0] = DW'(st);  e.val[1] = DW'(vl); e.val[2] = DW'(wr);
    e.val[3] = DW'(mrd); e.val[4] = DW'(mwr); e.val[5] = DW'(op);
    e.val[6] = DW'(rd);  e.val[7] = imm; e.val[8] = a; e.val[9] = b; e.val[10] = sd;
    e.val[11] = '0;
    return e;
  endfunction

  function automatic exp_t zero_exp(input string nm);
    return ex(nm, 0, 0, 0, 0, 0, 4'd0, 0, '0, '0, '0, '0);
  endfunction

  task automatic step(input vec_t v, input exp_t e);
    @(posedge clk);
    #1;
    rst_n = v.rst_n; id_valid = v.id_valid; id_op = v.id_op;
    id_rs = v.id_rs; id_rt = v.id_rt; id_rd = v.id_rd;
    id_rs_data = v.id_rs_data; id_rt_data = v.id_rt_data; id_imm = v.id_imm;
    id_use_imm = v.id_use_imm; id_use_rt = v.id_use_rt; id_wr_en = v.id_wr_en;
    id_mem_rd = v.id_mem_rd; id_mem_wr = v.id_mem_wr; flush = v.flush;
    exm_wr_en = v.exm_wr_en; exm_rd = v.exm_rd; exm_data = v.exm_data;
    wb_wr_en = v.wb_wr_en; wb_rd = v.wb_rd; wb_data = v.wb_data;
    sb.push_back(e);
  endtask

  // Monitor: compare every output against the queued expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [DW-1:0] act [NF];
      e = sb.pop_front();
      act[0] = DW'(stall);    act[1] = DW'(ex_valid); act[2] = DW'(ex_wr_en);
      act[3] = DW'(ex_mem_rd); act[4] = DW'(ex_mem_wr); act[5] = DW'(ex_op);
      act[6] = DW'(ex_rd);    act[7] = ex_imm; act[8] = ex_a; act[9] = ex_b;
      act[10] = ex_st_data;   act[11] = '0;
      for (int k = 0; k < NF - 1; k++) begin
        n_chk++;
        if (act[k] !== e.val[k]) begin
          n_fail++;
          $display("FAIL %s.%s: got %h, expected %h", e.name, fname[k], act[k], e.val[k]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // 1: reset held, ADD r3,r1,r2 presented
    v = ins(4'd0, 3, 1, 2, 32'h11, 32'h22, '0, 0, 1, 1, 0, 0); v.rst_n = 1'b0;
    step(v, zero_exp("reset_low"));
    // 2: release; stage still holds reset contents
    v.rst_n = 1'b1;
    step(v, zero_exp("reset_release"));
    // 3: ADD in EX; decode SUB r4,r3,r5
    v = ins(4'd1, 4, 3, 5, 32'h0, 32'h5, '0, 0, 1, 1, 0, 0);
    step(v, ex("add_first", 0, 1, 1, 0, 0, 4'd0, 3, '0, 32'h11, 32'h22, 32'h22));
    // 4: SUB in EX, ADD r3 in EX/MEM (0x55); decode OR r8,r3,r0
    v = ins(4'd3, 8, 3, 0, 32'h0, 32'h0, '0, 0, 1, 1, 0, 0);
    v.exm_wr_en = 1; v.exm_rd = 3; v.exm_data = 32'h55;
    step(v, ex("fwd_exm", 0, 1, 1, 0, 0, 4'd1, 4, '0, 32'h55, 32'h5, 32'h5));
    // 5: OR in EX; EX/MEM and MEM/WB both write r3; decode AND r9,r0,r0
    v = ins(4'd2, 9, 0, 0, 32'h0, 32'h0, '0, 0, 1, 1, 0, 0);
    v.exm_wr_en = 1; v.exm_rd = 3; v.exm_data = 32'h55;
    v.wb_wr_en = 1;  v.wb_rd = 3;  v.wb_data = 32'h77;
    step(v, ex("exm_over_wb", 0, 1, 1, 0, 0, 4'd3, 8, '0, 32'h55, 32'h0, 32'h0));
    // 6: AND in EX; both buses write r0; decode LW r2,4(r1)
    v = ins(4'd0, 2, 1, 0, 32'h100, 32'h0, 32'h4, 1, 0, 1, 1, 0);
    v.exm_wr_en = 1; v.exm_rd = 0; v.exm_data = 32'h99;
    v.wb_wr_en = 1;  v.wb_rd = 0;  v.wb_data = 32'hAA;
    step(v, ex("r0_no_fwd", 0, 1, 1, 0, 0, 4'd2, 9, '0, 32'h0, 32'h0, 32'h0));
    // 7: LW in EX; decode ADD r6,r2,r1 -> load-use stall
    v = ins(4'd0, 6, 2, 1, 32'hDEAD, 32'h100, '0, 0, 1, 1, 0, 0);
    step(v, ex("load_use", 1, 1, 1, 1, 0, 4'd0, 2, 32'h4, 32'h100, 32'h4, 32'h0));
    // 8: bubble in EX, stall gone; ADD re-presented
    v.exm_wr_en = 1; v.exm_rd = 2; v.exm_data = 32'h104;
    step(v, zero_exp("bubble"));
    // 9: ADD in EX with load data from MEM/WB; decode XOR r10,r2,r11 (capture bypass)
    v = ins(4'd4, 10, 2, 11, 32'hDEAD, 32'h3, '0, 0, 1, 1, 0, 0);
    v.wb_wr_en = 1; v.wb_rd = 2; v.wb_data = 32'hCAFE;
    step(v, ex("add_after_load", 0, 1, 1, 0, 0, 4'd0, 6, '0, 32'hCAFE, 32'h100, 32'h100));
    // 10: XOR in EX uses the bypassed capture; decode LW r5,0(r4)
    v = ins(4'd0, 5, 4, 0, 32'h200, 32'h0, 32'h0, 1, 0, 1, 1, 0);
    step(v, ex("capture_bypass", 0, 1, 1, 0, 0, 4'd4, 10, '0, 32'hCAFE, 32'h3, 32'h3));
    // 11: LW in EX; decode SUB r7,r1,r5 with flush -> no stall
    v = ins(4'd1, 7, 1, 5, 32'h1, 32'h2, '0, 0, 1, 1, 0, 0); v.flush = 1;
    step(v, ex("flush_vs_stall", 0, 1, 1, 1, 0, 4'd0, 5, '0, 32'h200, 32'h0, 32'h0));
    // 12: bubble from flush; decode SW r8,8(r4)
    v = ins(4'd0, 0, 4, 8, 32'h300, 32'h1, 32'h8, 1, 1, 0, 0, 1);
    step(v, zero_exp("flush_bubble"));
    // 13: SW in EX, EX/MEM writes r8
    v = nop(); v.exm_wr_en = 1; v.exm_rd = 8; v.exm_data = 32'hBEEF;
    step(v, ex("sw_imm", 0, 1, 0, 0, 1, 4'd0, 0, 32'h8, 32'h300, 32'h8, 32'hBEEF));
    // 14: idle in EX; decode LW r3,0(r1)
    v = ins(4'd0, 3, 1, 0, 32'h10, 32'h0, 32'h0, 1, 0, 1, 1, 0);
    step(v, zero_exp("idle"));
    // 15: LW in EX; decode ADD r4,r3,r2 -> stall
    v = ins(4'd0, 4, 3, 2, 32'h40, 32'h2, '0, 0, 1, 1, 0, 0);
    step(v, ex("stall2", 1, 1, 1, 1, 0, 4'd0, 3, '0, 32'h10, 32'h0, 32'h0));
    // 16: asynchronous reset mid-stall
    v.rst_n = 1'b0;
    step(v, zero_exp("reset_mid_stall"));
    // 17: release; held instruction dropped
    v.rst_n = 1'b1;
    step(v, zero_exp("reset_release2"));
    // 18: re-presented ADD issues
    v = nop();
    step(v, ex("reissue", 0, 1, 1, 0, 0, 4'd0, 4, '0, 32'h40, 32'h2, 32'h2));

    begin
      int waited = 0;
      while (sb.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (sb.size() > 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
